// File: rtl/compressed_stream_packer.sv
// Packs variable-length compressed elements back-to-back and emits fixed OUT_BYTES beats with keep/last.
// Optional PACKER_STATS_EN adds frame_cnt/byte_cnt counters on popped beats.
module compressed_stream_packer #(
    parameter  int IN_BYTES  = 34,
    parameter  int OUT_BYTES = 8,
    parameter  int BUF_BYTES = IN_BYTES + OUT_BYTES,
    localparam int CNT_W     = $clog2(BUF_BYTES + 1),
    localparam int IN_CNT_W  = $clog2(IN_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [IN_BYTES*8-1:0]  in_data,
    input  logic [IN_CNT_W-1:0]    in_count,
    input  logic                   in_last,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [OUT_BYTES*8-1:0] out_data,
    output logic [OUT_BYTES-1:0]   out_keep,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       fill_level
`ifdef PACKER_STATS_EN
    ,
    output logic [31:0]            frame_cnt,
    output logic [31:0]            byte_cnt
`endif
);

    localparam int BUF_W = BUF_BYTES * 8;
    localparam logic [CNT_W-1:0]    OUT_C  = CNT_W'(OUT_BYTES);
    localparam logic [CNT_W-1:0]    ROOM_C = CNT_W'(BUF_BYTES - IN_BYTES);
    localparam logic [IN_CNT_W-1:0] IN_C   = IN_CNT_W'(IN_BYTES);

    typedef enum logic {ACCUM, FLUSH} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     fill_q, fill_d;
    logic [BUF_W-1:0]     buf_q, buf_d;
    logic                 in_ready_q, in_ready_d;

    logic                 push, pop;
    logic [CNT_W-1:0]     pop_n, push_n, base;
    logic [IN_CNT_W-1:0]  cnt_cl;
    logic [IN_BYTES*8-1:0] ins_bytes;

    // Output decode depends only on registered state, never on in_* or out_ready.
    always_comb begin
        out_valid = (state_q == FLUSH) || (fill_q >= OUT_C);
        out_last  = (state_q == FLUSH) && (fill_q <= OUT_C);
        out_data  = out_valid ? buf_q[OUT_BYTES*8-1:0] : '0;
        out_keep  = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            out_keep[i] = out_valid && ((state_q == ACCUM) || (i < int'(fill_q)));
        end
    end

    always_comb begin
        push      = in_valid && in_ready_q;
        pop       = out_valid && out_ready;
        pop_n     = pop ? ((fill_q >= OUT_C) ? OUT_C : fill_q) : '0;
        cnt_cl    = (in_count > IN_C) ? IN_C : in_count;
        push_n    = push ? CNT_W'(cnt_cl) : '0;
        base      = fill_q - pop_n;
        fill_d    = base + push_n;
        ins_bytes = '0;
        for (int i = 0; i < IN_BYTES; i++) begin
            if (i < int'(push_n)) ins_bytes[i*8 +: 8] = in_data[i*8 +: 8];
        end
        // Bytes above fill are always zero, so shifting down and OR-ing the new element in is exact.
        buf_d = (buf_q >> {pop_n, 3'b000}) | (BUF_W'(ins_bytes) << {base, 3'b000});

        state_d = state_q;
        case (state_q)
            ACCUM:   if (push && in_last) state_d = FLUSH;
            FLUSH:   if (pop && out_last) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
        in_ready_d = (state_d == ACCUM) && (fill_d <= ROOM_C);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ACCUM;
            fill_q     <= '0;
            buf_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            buf_q      <= buf_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign fill_level = fill_q;

`ifdef PACKER_STATS_EN
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] byte_cnt_q, byte_cnt_d;

    // keep is contiguous, so its popcount equals the number of bytes popped.
    always_comb begin
        frame_cnt_d = frame_cnt_q + ((pop && out_last) ? 32'd1 : 32'd0);
        byte_cnt_d  = byte_cnt_q + 32'(pop_n);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_cnt_q <= '0;
            byte_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign byte_cnt  = byte_cnt_q;
`endif

endmodule

// File: tb/tb_compressed_stream_packer.sv
// Directed bench for compressed_stream_packer: table of single-element frames plus multi-cycle sequences.
module tb_compressed_stream_packer;

    localparam int IN_BYTES  = 34;
    localparam int OUT_BYTES = 8;
    localparam int CNT_W     = 6;
    localparam int IN_CNT_W  = 6;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic [IN_BYTES*8-1:0]  in_data;
    logic [IN_CNT_W-1:0]    in_count;
    logic                   in_last;
    logic                   in_valid;
    logic                   in_ready;
    logic [OUT_BYTES*8-1:0] out_data;
    logic [OUT_BYTES-1:0]   out_keep;
    logic                   out_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [CNT_W-1:0]       fill_level;
`ifdef PACKER_STATS_EN
    logic [31:0]            frame_cnt;
    logic [31:0]            byte_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    compressed_stream_packer dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_data    (in_data),
        .in_count   (in_count),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_level (fill_level)
`ifdef PACKER_STATS_EN
        ,
        .frame_cnt  (frame_cnt),
        .byte_cnt   (byte_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the element was accepted.
    task automatic push(input int cnt, input logic [7:0] start, input logic last);
        int t;
        in_data = '0;
        for (int k = 0; k < IN_BYTES; k++) begin
            if (k < cnt) in_data[k*8 +: 8] = start + 8'(k);
        end
        in_count = IN_CNT_W'(cnt);
        in_last  = last;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("push_ready_timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Expects beats carrying bytes start, start+1, ... ; out_ready must be 1.
    task automatic collect(input logic [7:0] start, input int beats, input logic [7:0] last_keep,
                           input string name);
        int t;
        int nk;
        logic [7:0]  ek;
        logic [63:0] ed;
        for (int j = 0; j < beats; j++) begin
            t = 0;
            while (!out_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!out_valid) begin
                chk({name, "_valid_timeout"}, {63'd0, out_valid}, 64'd1);
                return;
            end
            ek = (j == beats - 1) ? last_keep : 8'hFF;
            nk = 0;
            for (int k = 0; k < 8; k++) if (ek[k]) nk++;
            ed = '0;
            for (int k = 0; k < nk; k++) ed[k*8 +: 8] = start + 8'(j*8 + k);
            chk({name, "_data"}, out_data, ed);
            chk({name, "_keep"}, {56'd0, out_keep}, {56'd0, ek});
            chk({name, "_last"}, {63'd0, out_last}, {63'd0, (j == beats - 1)});
            @(negedge clk);
        end
    endtask

    typedef struct {
        int         cnt;
        logic [7:0] start;
        int         beats;
        logic [7:0] last_keep;
        string      name;
    } vec_t;

    vec_t vecs[7];

    logic [63:0] held_data;

    initial begin
        vecs[0] = '{5,  8'h01, 1, 8'h1F, "five_bytes"};
        vecs[1] = '{0,  8'h00, 1, 8'h00, "empty_frame"};
        vecs[2] = '{8,  8'h10, 1, 8'hFF, "exact_beat"};
        vecs[3] = '{9,  8'h20, 2, 8'h01, "nine_bytes"};
        vecs[4] = '{34, 8'h40, 5, 8'h03, "full_elem"};
        vecs[5] = '{16, 8'h80, 2, 8'hFF, "two_beats"};
        vecs[6] = '{40, 8'hA0, 5, 8'h03, "clamped_cnt"};

        resetn = 1'b0; in_data = '0; in_count = '0; in_last = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data",  out_data, 64'd0);
        chk("rst_out_keep",  {56'd0, out_keep}, 64'd0);
        chk("rst_out_last",  {63'd0, out_last}, 64'd0);
        chk("rst_fill",      {58'd0, fill_level}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rel_fill",     {58'd0, fill_level}, 64'd0);

        // Table of single-element frames, drained with out_ready high
        out_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            push(vecs[v].cnt, vecs[v].start, 1'b1);
            collect(vecs[v].start, vecs[v].beats, vecs[v].last_keep, vecs[v].name);
            chk({vecs[v].name, "_fill_after"}, {58'd0, fill_level}, 64'd0);
            chk({vecs[v].name, "_ready_after"}, {63'd0, in_ready}, 64'd1);
        end

        // Two 34-byte elements in one frame: continuous byte order across the boundary
        fork
            begin
                push(34, 8'h00, 1'b0);
                push(34, 8'h22, 1'b1);
            end
            collect(8'h00, 9, 8'h0F, "two_elem");
        join
        chk("two_elem_fill_after", {58'd0, fill_level}, 64'd0);

        // Backpressure: in_ready drops above fill 8 and the first beat holds steady
        out_ready = 1'b0;
        push(34, 8'h50, 1'b0);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("bp_fill",         {58'd0, fill_level}, 64'd34);
        held_data = out_data;
        repeat (3) @(negedge clk);
        chk("bp_stable_data", out_data, held_data);
        chk("bp_stable_keep", {56'd0, out_keep}, 64'hFF);
        chk("bp_stable_last", {63'd0, out_last}, 64'd0);
        fork
            push(8, 8'h72, 1'b1);
            begin
                out_ready = 1'b1;
                collect(8'h50, 6, 8'h03, "bp_drain");
            end
        join
        chk("bp_ready_back", {63'd0, in_ready}, 64'd1);

        // Simultaneous push and pop at fill 8
        out_ready = 1'b0;
        push(8, 8'hC0, 1'b0);
        chk("sim_fill_pre",  {58'd0, fill_level}, 64'd8);
        chk("sim_ready_pre", {63'd0, in_ready}, 64'd1);
        chk("sim_data_pre",  out_data, 64'hC7C6C5C4C3C2C1C0);
        out_ready = 1'b1;
        push(8, 8'hC8, 1'b1);
        chk("sim_fill_post", {58'd0, fill_level}, 64'd8);
        collect(8'hC8, 1, 8'hFF, "sim_second");
        chk("sim_fill_after", {58'd0, fill_level}, 64'd0);

        // Mid-frame asynchronous reset while flushing
        out_ready = 1'b0;
        push(20, 8'h30, 1'b1);
        chk("mid_fill",  {58'd0, fill_level}, 64'd20);
        chk("mid_valid", {63'd0, out_valid}, 64'd1);
        chk("mid_last",  {63'd0, out_last}, 64'd0);
        #2 resetn = 1'b0;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_data",  out_data, 64'd0);
        chk("arst_keep",  {56'd0, out_keep}, 64'd0);
        chk("arst_last",  {63'd0, out_last}, 64'd0);
        chk("arst_ready", {63'd0, in_ready}, 64'd0);
        chk("arst_fill",  {58'd0, fill_level}, 64'd0);
`ifdef PACKER_STATS_EN
        chk("arst_frame_cnt", {32'd0, frame_cnt}, 64'd0);
        chk("arst_byte_cnt",  {32'd0, byte_cnt}, 64'd0);
`endif
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        push(5, 8'h61, 1'b1);
        collect(8'h61, 1, 8'h1F, "post_rst_frame");
        chk("post_rst_fill", {58'd0, fill_level}, 64'd0);
`ifdef PACKER_STATS_EN
        chk("stats_frame_cnt", {32'd0, frame_cnt}, 64'd1);
        chk("stats_byte_cnt",  {32'd0, byte_cnt}, 64'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
